// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, line constants and parity helper for the FIFO-draining UART.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: counts clocks within one UART bit and flags the last and second-to-last cycle.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] PRE  = W'(CLKS_PER_BIT - 2);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clear ? '0 : !enable ? cnt_q : (cnt_q == LAST) ? '0 : cnt_q + W'(1);

    always_ff @(posedge clock or negedge reset)
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    // pre_end lets the parent register a pulse that lands on the bit's final cycle
    assign bit_end     = enable && !clear && cnt_q == LAST;
    assign bit_pre_end = enable && !clear && cnt_q == PRE;

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an upstream FIFO and serialises each as an 8N1/8E1 UART frame.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tx_Enable,
    input  logic                 fifo_Empty,
    input  logic [DATA_BITS-1:0] fifo_Data,
    output logic                 read_Enable,
    output logic                 tx_Serial,
    output logic                 tx_Busy,
    output logic                 tx_Done
);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_q, par_d;
    logic [2:0]           idx_q, idx_d;
    logic                 rd_q, rd_d;
    logic                 ser_q, ser_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cnt_clr, cnt_en, bit_end, bit_pre_end;

    assign cnt_clr = state_q == LOAD;
    assign cnt_en  = state_q inside {START, DATA, PARITY, STOP};

    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clock       (clock),
        .reset       (reset),
        .clear       (cnt_clr),
        .enable      (cnt_en),
        .bit_end     (bit_end),
        .bit_pre_end (bit_pre_end)
    );

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        par_d   = par_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE:    state_d = (tx_Enable && !fifo_Empty) ? FETCH : IDLE;
            FETCH:   state_d = LOAD;
            LOAD: begin
                sh_d    = fifo_Data;
                par_d   = even_parity(fifo_Data);
                idx_d   = '0;
                state_d = START;
            end
            START:   state_d = bit_end ? DATA : START;
            DATA: begin
                if (bit_end) begin
                    sh_d    = sh_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    state_d = (idx_q == 3'd7) ? (PARITY_EN ? PARITY : STOP) : DATA;
                end
            end
            PARITY:  state_d = bit_end ? STOP : PARITY;
            STOP:    state_d = bit_end ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change together with it
    always_comb begin
        rd_d   = state_d == FETCH;
        busy_d = state_d != IDLE;
        done_d = state_q == STOP && bit_pre_end;
        ser_d  = state_d == START  ? 1'b0 :
                 state_d == DATA   ? sh_d[0] :
                 state_d == PARITY ? par_q : UART_IDLE_LEVEL;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            par_q   <= 1'b0;
            idx_q   <= '0;
            rd_q    <= 1'b0;
            ser_q   <= UART_IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            ser_q   <= ser_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign read_Enable = rd_q;
    assign tx_Serial   = ser_q;
    assign tx_Busy     = busy_q;
    assign tx_Done     = done_q;

endmodule
